// File: rtl/l2_pkg.sv
// Shared constants for the L2 responder: FSM encoding and default geometry.
package l2_pkg;

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] WB       = 2'b01;
  localparam logic [1:0] RD_WAIT  = 2'b10;
  localparam logic [1:0] RD_BURST = 2'b11;

  localparam int DEF_BEATS  = 8;
  localparam int DEF_RD_LAT = 4;

endpackage

// File: rtl/l2_responder_if.sv
// L1D <-> L2 miss/writeback bus. master = L1D side, slave = L2 side.
interface l2_responder_if #(
  parameter int DATA_W = 32
);
  logic              read_l2;
  logic              write_l2;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              l2_ack;
  logic              wb_done;
  logic              busy;

  modport master (
    output read_l2, write_l2, addr, wdata,
    input  rdata, rdata_valid, l2_ack, wb_done, busy
  );

  modport slave (
    input  read_l2, write_l2, addr, wdata,
    output rdata, rdata_valid, l2_ack, wb_done, busy
  );
endinterface

// File: rtl/l2_beat_counter.sv
// Up-counter with synchronous clear/enable; tc flags the all-ones count.
module l2_beat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // clear wins over enable; count wraps naturally at 2**W
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en)      cnt <= cnt + W'(1);
  end

  assign tc = &cnt;

endmodule

// File: rtl/l2_responder.sv
// L2-side responder: fixed-latency block refills and dirty-block writebacks
// against a local single-port word array. BEATS must be >= 2.
module l2_responder
  import l2_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BEATS     = DEF_BEATS,
  parameter int MEM_WORDS = 4096,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic           clk,
  input  logic           reset,
  l2_responder_if.slave  bus
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = $clog2(BEATS);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [1:0]        state, state_nxt;
  logic [LW-1:0]     lat_cnt, lat_nxt;
  logic [BW-1:0]     beat_cnt;
  logic              bc_clr, bc_en, bc_tc;
  logic [AW-BW-1:0]  block_base;
  logic [BW-1:0]     beat_idx;
  logic [AW-1:0]     mem_idx;
  logic              mem_we, mem_re;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic              unused_addr;

  l2_beat_counter #(.W(BW)) u_beat_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bc_clr),
    .en    (bc_en),
    .cnt   (beat_cnt),
    .tc    (bc_tc)
  );

  assign block_base  = bus.addr[AW+1:BW+2];
  assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[BW+1:0]};

  // During the burst, beat_cnt is the beat on rdata, so the RAM is one ahead.
  assign beat_idx = (state == RD_BURST) ? beat_cnt + BW'(1) : beat_cnt;
  assign mem_idx  = {block_base, beat_idx};

  // Beat 0 of a writeback lands in the IDLE cycle that accepts it.
  assign mem_we = !reset && bus.write_l2 && (state == IDLE || state == WB);
  // Last wait cycle prefetches beat 0 so it is on rdata in the first burst cycle.
  assign mem_re = (state == RD_WAIT && lat_cnt == '0) || (state == RD_BURST);

  // Next state, latency countdown and beat counter control.
  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    bc_clr    = 1'b0;
    bc_en     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.write_l2) begin
          state_nxt = WB;
          bc_en     = 1'b1;
        end else begin
          bc_clr = 1'b1;
          if (bus.read_l2) begin
            state_nxt = RD_WAIT;
            lat_nxt   = LW'(RD_LAT - 1);
          end
        end
      end
      WB: begin
        if (bus.write_l2) begin
          bc_en = 1'b1;
          if (bc_tc) state_nxt = IDLE;
        end else begin
          bc_clr    = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD_WAIT: begin
        bc_clr = 1'b1;
        if (!bus.read_l2)       state_nxt = IDLE;
        else if (lat_cnt == '0) state_nxt = RD_BURST;
        else                    lat_nxt   = lat_cnt - LW'(1);
      end
      RD_BURST: begin
        if (bus.read_l2) begin
          bc_en = 1'b1;
          if (bc_tc) state_nxt = IDLE;
        end else begin
          bc_clr    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and latency counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_nxt;
    end
  end

  // Word array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= bus.wdata;
  end

  // Registered read data, cleared by reset so rdata is 0 out of reset.
  always_ff @(posedge clk) begin
    if (reset)       rdata_q <= '0;
    else if (mem_re) rdata_q <= mem[mem_idx];
  end

  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = (state == RD_BURST);
  assign bus.l2_ack      = (state == RD_BURST) && bc_tc;
  assign bus.wb_done     = (state == WB) && bus.write_l2 && bc_tc;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_l2_responder.sv
// Directed bench for l2_responder: writebacks, refills, aborts, priority,
// back-to-back and mid-burst reset, against a word-array model.
module tb_l2_responder;

  localparam int DATA_W = 32;
  localparam int BEATS  = 8;
  localparam int RD_LAT = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] model [4096];

  l2_responder_if #(.DATA_W(DATA_W)) bus ();

  l2_responder #(
    .DATA_W(DATA_W), .BEATS(BEATS), .MEM_WORDS(4096), .RD_LAT(RD_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [31:0] a, input int beat);
    return (int'((a >> 5) & 32'h1FF) << 3) + beat;
  endfunction

  // Writes n beats of base+i; current cycle must be IDLE. Model tracks commits.
  task automatic do_write(input logic [31:0] a, input logic [31:0] base, input int n);
    bus.addr     = a;
    bus.write_l2 = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.wdata = base + 32'(i);
      model[widx(a, i)] = base + 32'(i);
      @(negedge clk);
      chk($sformatf("wb_done b%0d", i), {31'd0, bus.wb_done}, {31'd0, i == BEATS - 1});
      chk($sformatf("wb_busy b%0d", i), {31'd0, bus.busy}, {31'd0, i != 0});
      step();
    end
    bus.write_l2 = 1'b0;
    if (n != BEATS) begin
      @(negedge clk);
      chk("wb_abort_done", {31'd0, bus.wb_done}, 32'd0);
      step();
    end
  endtask

  // Refill; current cycle is T (read_l2 first seen in IDLE). abort_k<0 = none.
  task automatic do_read(input logic [31:0] a, input int abort_k);
    int  last;
    logic live;
    last = RD_LAT + BEATS;
    bus.addr    = a;
    bus.read_l2 = 1'b1;
    for (int k = 0; k <= last; k++) begin
      if (k == abort_k) bus.read_l2 = 1'b0;
      live = (abort_k < 0) || (k <= abort_k);
      @(negedge clk);
      chk($sformatf("rvalid k%0d", k), {31'd0, bus.rdata_valid},
          {31'd0, live && k >= RD_LAT + 1 && k <= last});
      chk($sformatf("ack k%0d", k), {31'd0, bus.l2_ack}, {31'd0, live && k == last});
      chk($sformatf("rbusy k%0d", k), {31'd0, bus.busy}, {31'd0, live && k >= 1 && k <= last});
      if (live && k >= RD_LAT + 1)
        chk($sformatf("rdata k%0d", k), bus.rdata, model[widx(a, k - RD_LAT - 1)]);
      step();
    end
    bus.read_l2 = 1'b0;
    @(negedge clk);
    chk("rd_end_busy", {31'd0, bus.busy}, 32'd0);
    chk("rd_end_valid", {31'd0, bus.rdata_valid}, 32'd0);
    step();
  endtask

  initial begin
    reset        = 1'b1;
    bus.read_l2  = 1'b0;
    bus.write_l2 = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_busy",   {31'd0, bus.busy},        32'd0);
    chk("rst_valid",  {31'd0, bus.rdata_valid}, 32'd0);
    chk("rst_ack",    {31'd0, bus.l2_ack},      32'd0);
    chk("rst_wbdone", {31'd0, bus.wb_done},     32'd0);
    chk("rst_rdata",  bus.rdata,                32'd0);
    step();
    reset = 1'b0;
    step();

    // full writeback to words 0x48..0x4F, then refill it
    do_write(32'h0000_0120, 32'hA0, BEATS);
    do_read(32'h0000_0120, -1);

    // low address bits ignored; abort refill in second burst beat
    do_read(32'h0000_013C, 6);

    // partial writeback: 3 beats committed, rest keep A3..A7
    do_write(32'h0000_0120, 32'hB0, 3);
    do_read(32'h0000_0120, -1);

    // simultaneous request: write wins, held read returns the new data
    bus.read_l2 = 1'b1;
    do_write(32'h0000_0200, 32'hC0, BEATS);
    do_read(32'h0000_0200, -1);

    // back-to-back: read raised in the cycle right after wb_done
    do_write(32'h0000_02E0, 32'hD0, BEATS);
    do_read(32'h0000_02E0, -1);

    // reset for 2 cycles in the middle of a burst
    bus.addr    = 32'h0000_0200;
    bus.read_l2 = 1'b1;
    repeat (8) step();
    @(negedge clk);
    chk("mid_valid", {31'd0, bus.rdata_valid}, 32'd1);
    step();
    reset = 1'b1;
    step();
    step();
    reset       = 1'b0;
    bus.read_l2 = 1'b0;
    @(negedge clk);
    chk("mrst_busy",   {31'd0, bus.busy},        32'd0);
    chk("mrst_valid",  {31'd0, bus.rdata_valid}, 32'd0);
    chk("mrst_ack",    {31'd0, bus.l2_ack},      32'd0);
    chk("mrst_wbdone", {31'd0, bus.wb_done},     32'd0);
    chk("mrst_rdata",  bus.rdata,                32'd0);
    step();
    // upper address bits alias onto block 0x120
    do_read(32'h0000_4120, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/l2_responder.md
Name: l2_responder

Overview:
- L2-side responder for the L1D miss/writeback interface.
- Services block refills: holds `read_l2` → returns 8 data beats, then `l2_ack`.
- Services dirty-block writebacks: holds `write_l2` → accepts 8 data beats into a local word array, then `wb_done`.
- Sits between the L1D cache controller and the backing store; models L2 with fixed access latency.

Parameters:
- DATA_W, 32, data beat width in bits.
- BEATS, 8, beats per block; must be a power of 2.
- MEM_WORDS, 4096, words in the L2 array; must be a power of 2.
- RD_LAT, 4, cycles from read acceptance to first data beat; must be ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- read_l2  in  1  refill request; level, held by L1 until `l2_ack`.
- write_l2  in  1  writeback request; level, one beat transferred per cycle while high.
- addr  in  32  byte address of the block; low log2(BEATS)+2 bits ignored.
- wdata  in  DATA_W  writeback beat, valid every cycle `write_l2`=1.
- rdata  out  DATA_W  refill beat.
- rdata_valid  out  1  `rdata` valid this cycle.
- l2_ack  out  1  one-cycle pulse coincident with the final refill beat.
- wb_done  out  1  one-cycle pulse coincident with the final writeback beat being written.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high.
  - On reset: state=IDLE, beat_cnt=0, lat_cnt=0.
  - All outputs are 0 on reset, including `rdata`.
  - Array contents are not reset.
  - Reset mid-transaction aborts the transaction; beats already written stay written.
- Addressing: block_base = addr[log2(MEM_WORDS)+1 : log2(BEATS)+2]; word index = {block_base, beat_cnt}. `addr` is sampled every cycle; L1 must hold it stable for the whole transaction.
- States:
  - IDLE:
    - `write_l2`=1 → WB. The beat 0 write happens in this same cycle, so `write_l2` has priority over `read_l2`.
    - Else `read_l2`=1 → RD_WAIT with lat_cnt=RD_LAT-1.
    - Else stay in IDLE.
  - WB:
    - Each cycle `write_l2`=1: mem[index] ← wdata, beat_cnt++.
    - On the write of beat BEATS-1: `wb_done`=1 (combinational from state and count), beat_cnt wraps to 0, → IDLE.
    - `write_l2` dropping before the last beat → IDLE; beat_cnt=0; no `wb_done`; partial beats remain committed.
  - RD_WAIT:
    - lat_cnt counts down; at 0 → RD_BURST with beat_cnt=0.
    - `read_l2`=0 at any cycle → IDLE, no ack.
  - RD_BURST:
    - `rdata` = mem[index], registered, so each beat is presented 1 cycle after its index; `rdata_valid`=1 for exactly BEATS consecutive cycles.
    - `l2_ack`=1 in the same cycle as the beat with index BEATS-1, then → IDLE.
    - `read_l2`=0 mid-burst → IDLE, `rdata_valid` low from the next cycle, no `l2_ack`.
- Latency: first `rdata_valid` exactly RD_LAT+1 cycles after the cycle `read_l2` is first sampled high in IDLE. `l2_ack` RD_LAT+BEATS cycles after that sample.
- Back-to-back: a new request is accepted in the first IDLE cycle after `l2_ack` or `wb_done`, so there is no dead cycle beyond the return to IDLE.
- Read-after-write: a refill of the same block that started after `wb_done` returns the new data.
- Simultaneous `read_l2` and `write_l2` in IDLE: write wins; the read is serviced afterwards if still held.
- beat_cnt is log2(BEATS) bits and wraps naturally. lat_cnt is clog2(RD_LAT) bits, minimum 1.

Decomposition:
- Shared package `l2_pkg`:
  - state encoding localparams: IDLE=2'b00, WB=2'b01, RD_WAIT=2'b10, RD_BURST=2'b11;
  - default BEATS and RD_LAT.
- One sub-module: `l2_beat_counter`, a parameterised up-counter with synchronous clear, enable and terminal-count output. It is instantiated for beat_cnt.
- The latency down-counter stays inline.
- The array is an inferred single-port RAM inside `l2_responder`.

Test Plan:
- Reset: assert `reset` for 2 cycles mid-burst → next cycle `busy`=0, `rdata_valid`=0, `l2_ack`=0, `wb_done`=0; a following read completes normally.
- Writeback: addr=0x0000_0120, `write_l2` high 8 cycles with wdata=0xA0..0xA7 → `wb_done`=1 only in the 8th cycle; mem words 0x48..0x4F hold 0xA0..0xA7.
- Refill with RD_LAT=4: `read_l2` high at cycle T, addr=0x0000_0120 → `rdata_valid` cycles T+5..T+12 with rdata 0xA0..0xA7; `l2_ack`=1 only at T+12; drop `read_l2` at T+13 → IDLE.
- Aborts:
  - drop `read_l2` at T+6 → no further `rdata_valid`, no `l2_ack`, `busy`=0 at T+7;
  - drop `write_l2` after 3 beats → no `wb_done`, words 0..2 updated, words 3..7 unchanged.
- Simultaneous request: `read_l2`=`write_l2`=1 in IDLE → WB completes first (`wb_done` after 8 beats); a read held high then returns the just-written data.
- Back-to-back: a read issued in the cycle after `wb_done` → first `rdata_valid` exactly RD_LAT+1 cycles later.
